// File: rtl/sha256_round_ctrl.sv
// Round sequencer for the main_block SHA-256 datapath: LOAD A..H, ROUNDS strobes, READ A..H.
// Define SHA_IV_ROM_EN to take the LOAD values from the built-in SHA-256 initial hash.
module sha256_round_ctrl #(
    parameter int ROUNDS = 64,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [31:0]       iv_word,
    output logic [2:0]        iv_idx,
    input  logic [31:0]       w_data,
    input  logic              w_valid,
    output logic              w_ready,
    output logic [31:0]       out_word,
    output logic [2:0]        out_idx,
    output logic              out_valid,
    output logic [31:0]       dp_in_var,
    output logic [31:0]       dp_in_w,
    output logic [5:0]        dp_k_num,
    output logic [ADDR_W-1:0] dp_mem_in_addr,
    output logic [ADDR_W-1:0] dp_mem_out_addr,
    output logic              dp_en_mem_out,
    input  logic [31:0]       dp_out_var
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic [5:0]        t_r;
    logic              busy_r;
    logic              done_r;
    logic              w_ready_r;
    logic              out_valid_r;
    logic              en_mem_out_r;
    logic [2:0]        iv_idx_r;
    logic [2:0]        out_idx_r;
    logic [31:0]       out_word_r;
    logic [ADDR_W-1:0] mem_in_addr_r;
    logic [ADDR_W-1:0] mem_out_addr_r;
    logic              round_s;
    logic              strobe_s;

`ifdef SHA_IV_ROM_EN
    logic unused_iv_s;

    function automatic logic [31:0] iv_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    iv_rom = 32'h6a09e667;
            3'd1:    iv_rom = 32'hbb67ae85;
            3'd2:    iv_rom = 32'h3c6ef372;
            3'd3:    iv_rom = 32'ha54ff53a;
            3'd4:    iv_rom = 32'h510e527f;
            3'd5:    iv_rom = 32'h9b05688c;
            3'd6:    iv_rom = 32'h1f83d9ab;
            3'd7:    iv_rom = 32'h5be0cd19;
            default: iv_rom = 32'h00000000;
        endcase
    endfunction

    assign unused_iv_s = ^iv_word;
    assign dp_in_var   = (state_r == S_LOAD) ? iv_rom(iv_idx_r) : 32'd0;
`else
    // The IV source tracks iv_idx and presents its word in the same cycle.
    assign dp_in_var   = (state_r == S_LOAD) ? iv_word : 32'd0;
`endif

    // A round strobe happens exactly when a schedule word is handed over, so the
    // ROUND-phase command follows w_valid within the cycle.
    assign round_s         = (state_r == S_ROUND);
    assign strobe_s        = round_s & w_valid;
    assign dp_en_mem_out   = round_s ? ~w_valid : en_mem_out_r;
    assign dp_in_w         = strobe_s ? w_data : 32'd0;
    assign dp_k_num        = strobe_s ? t_r : 6'd0;
    assign dp_mem_in_addr  = mem_in_addr_r;
    assign dp_mem_out_addr = mem_out_addr_r;

    assign busy      = busy_r;
    assign done      = done_r;
    assign w_ready   = w_ready_r;
    assign iv_idx    = iv_idx_r;
    assign out_word  = out_word_r;
    assign out_idx   = out_idx_r;
    assign out_valid = out_valid_r;

    // Phase sequencer with registered status, stream and datapath-address outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= S_IDLE;
            cnt_r          <= 4'd0;
            t_r            <= 6'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            w_ready_r      <= 1'b0;
            out_valid_r    <= 1'b0;
            en_mem_out_r   <= 1'b1;
            iv_idx_r       <= 3'd0;
            out_idx_r      <= 3'd0;
            out_word_r     <= 32'd0;
            mem_in_addr_r  <= '0;
            mem_out_addr_r <= '0;
        end else begin
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_idx_r   <= 3'd0;
            out_word_r  <= 32'd0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r       <= S_LOAD;
                        busy_r        <= 1'b1;
                        cnt_r         <= 4'd0;
                        iv_idx_r      <= 3'd0;
                        en_mem_out_r  <= 1'b0;
                        mem_in_addr_r <= ADDR_W'(4'd1);
                    end else begin
                        en_mem_out_r  <= 1'b1;
                        mem_in_addr_r <= '0;
                    end
                end
                S_LOAD: begin
                    if (cnt_r == 4'd7) begin
                        state_r       <= S_ROUND;
                        w_ready_r     <= 1'b1;
                        t_r           <= 6'd0;
                        cnt_r         <= 4'd0;
                        iv_idx_r      <= 3'd0;
                        en_mem_out_r  <= 1'b1;
                        mem_in_addr_r <= '0;
                    end else begin
                        cnt_r         <= cnt_r + 4'd1;
                        iv_idx_r      <= iv_idx_r + 3'd1;
                        mem_in_addr_r <= mem_in_addr_r + ADDR_W'(4'd1);
                    end
                end
                S_ROUND: begin
                    if (w_valid && (t_r == LAST_T)) begin
                        state_r        <= S_READ;
                        w_ready_r      <= 1'b0;
                        t_r            <= 6'd0;
                        cnt_r          <= 4'd0;
                        mem_out_addr_r <= ADDR_W'(4'd1);
                    end else if (w_valid) begin
                        t_r <= t_r + 6'd1;
                    end else begin
                        t_r <= t_r;
                    end
                end
                S_READ: begin
                    // Word j is read combinationally in cycle j and presented in cycle j+1.
                    if (cnt_r <= 4'd7) begin
                        out_valid_r <= 1'b1;
                        out_idx_r   <= cnt_r[2:0];
                        out_word_r  <= dp_out_var;
                    end
                    if (cnt_r < 4'd7) begin
                        mem_out_addr_r <= ADDR_W'(cnt_r) + ADDR_W'(4'd2);
                    end else begin
                        mem_out_addr_r <= '0;
                    end
                    if (cnt_r == 4'd8) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r        <= S_IDLE;
                    busy_r         <= 1'b0;
                    w_ready_r      <= 1'b0;
                    en_mem_out_r   <= 1'b1;
                    mem_in_addr_r  <= '0;
                    mem_out_addr_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: behavioural main_block, SHA-256 reference,
// table-driven compressions, stalls, mid-run reset and random runs.
module tb_sha256_round_ctrl;

    localparam int ROUNDS = 64;

    typedef logic [7:0][31:0] st8_t;

    typedef struct {
        int          stall_t;
        int          stall_len;
        int          exp_lat;
        logic [31:0] exp_a;
        logic [31:0] exp_h;
        bit          pulse;
    } vec_t;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam st8_t SHA_IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                               32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    logic        clk = 1'b0;
    logic        rst_n, start, w_valid;
    logic [31:0] w_data, iv_word, out_word, dp_in_var, dp_in_w, dp_out_var;
    logic [2:0]  iv_idx, out_idx;
    logic        busy, done, w_ready, out_valid, dp_en_mem_out;
    logic [5:0]  dp_k_num;
    logic [3:0]  dp_mem_in_addr, dp_mem_out_addr;

    st8_t        iv_src;
    st8_t        mb_reg;
    logic [31:0] msg_w [64];
    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          outv_cnt = 0;

    always #5 clk = ~clk;

    sha256_round_ctrl #(.ROUNDS(ROUNDS), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .iv_word(iv_word), .iv_idx(iv_idx), .w_data(w_data), .w_valid(w_valid),
        .w_ready(w_ready), .out_word(out_word), .out_idx(out_idx), .out_valid(out_valid),
        .dp_in_var(dp_in_var), .dp_in_w(dp_in_w), .dp_k_num(dp_k_num),
        .dp_mem_in_addr(dp_mem_in_addr), .dp_mem_out_addr(dp_mem_out_addr),
        .dp_en_mem_out(dp_en_mem_out), .dp_out_var(dp_out_var)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic st8_t sha_round(input st8_t s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] t1, t2;
        st8_t r;
        t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25))
                  + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
        t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22))
           + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        r[0] = t1 + t2; r[1] = s[0]; r[2] = s[1]; r[3] = s[2];
        r[4] = s[3] + t1; r[5] = s[4]; r[6] = s[5]; r[7] = s[6];
        return r;
    endfunction

    function automatic st8_t ref_compress(input st8_t iv);
        st8_t s = iv;
        for (int t = 0; t < ROUNDS; t++) s = sha_round(s, K_TAB[t], msg_w[t]);
        return s;
    endfunction

    function automatic st8_t exp_iv();
`ifdef SHA_IV_ROM_EN
        return SHA_IV;
`else
        return iv_src;
`endif
    endfunction

    // Behavioural main_block: register file 1..8, round on ROUND, combinational read.
    always @(posedge clk) begin
        if (!dp_en_mem_out) begin
            if (dp_mem_in_addr >= 4'd1 && dp_mem_in_addr <= 4'd8)
                mb_reg[3'(dp_mem_in_addr - 4'd1)] <= dp_in_var;
            else if (dp_mem_in_addr == 4'd0 && dp_mem_out_addr == 4'd0)
                mb_reg <= sha_round(mb_reg, K_TAB[dp_k_num], dp_in_w);
        end
    end
    assign dp_out_var = (dp_en_mem_out && dp_mem_out_addr >= 4'd1 && dp_mem_out_addr <= 4'd8)
                        ? mb_reg[3'(dp_mem_out_addr - 4'd1)] : 32'h0;
    assign iv_word = iv_src[iv_idx];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid) outv_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_word"}, out_word, 32'd0);
        chk({tag, "_w_ready"}, 32'(w_ready), 32'd0);
        chk({tag, "_en_mem_out"}, 32'(dp_en_mem_out), 32'd1);
        chk({tag, "_in_addr"}, 32'(dp_mem_in_addr), 32'd0);
        chk({tag, "_out_addr"}, 32'(dp_mem_out_addr), 32'd0);
        chk({tag, "_k_num"}, 32'(dp_k_num), 32'd0);
        chk({tag, "_in_var"}, dp_in_var, 32'd0);
        chk({tag, "_in_w"}, dp_in_w, 32'd0);
    endtask

    task automatic expand_schedule();
        for (int t = 16; t < 64; t++)
            msg_w[t] = (ror(msg_w[t-2], 17) ^ ror(msg_w[t-2], 19) ^ (msg_w[t-2] >> 10)) + msg_w[t-7]
                     + (ror(msg_w[t-15], 7) ^ ror(msg_w[t-15], 18) ^ (msg_w[t-15] >> 3)) + msg_w[t-16];
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) msg_w[i] = 32'h0;
        msg_w[0]  = 32'h61626380;
        msg_w[15] = 32'h00000018;
        expand_schedule();
    endtask

    // One compression; latency is start-cycle..done-cycle inclusive, -1 if aborted by reset.
    task automatic run_comp(input int stall_t, input int stall_len, input int pct, input bit pulse,
                            input int abort_t, output int latency, output st8_t got,
                            output int nwords, output int stalls);
        int cyc, t_tb, stall_left;
        bit hs, seen_done;
        st8_t ivx;
        ivx = exp_iv();
        latency = -1; got = '0; nwords = 0; stalls = 0;
        t_tb = 0; stall_left = stall_len; seen_done = 1'b0;
        @(negedge clk); start = 1'b1; w_valid = 1'b0;
        @(posedge clk); cyc = 1;
        while (!seen_done && cyc < 400) begin
            @(negedge clk);
            start = pulse && (cyc == 5 || cyc == 40 || done);
            if (abort_t >= 0 && w_ready && t_tb == abort_t) begin
                rst_n = 1'b0; w_valid = 1'b0; start = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk); rst_n = 1'b1;
                #1 check_idle("abort");
                repeat (20) @(negedge clk);
                return;
            end
            if (w_ready && t_tb < ROUNDS) begin
                if (t_tb == stall_t && stall_left > 0) begin
                    w_valid = 1'b0; stall_left--;
                end else if (pct > 0 && int'($urandom_range(99)) < pct) w_valid = 1'b0;
                else w_valid = 1'b1;
            end else w_valid = 1'($urandom_range(1));
            w_data = (w_valid && w_ready && t_tb < ROUNDS) ? msg_w[t_tb] : $urandom;
            #1;
            if (cyc <= 8) begin
                chk($sformatf("load%0d_addr", cyc), 32'(dp_mem_in_addr), 32'(cyc));
                chk($sformatf("load%0d_en", cyc), 32'(dp_en_mem_out), 32'd0);
                chk($sformatf("load%0d_var", cyc), dp_in_var, ivx[cyc-1]);
                chk($sformatf("load%0d_idx", cyc), 32'(iv_idx), 32'(cyc - 1));
            end
            if (w_ready) begin
                if (!w_valid) begin
                    stalls++;
                    chk($sformatf("nop_t%0d_en", t_tb), 32'(dp_en_mem_out), 32'd1);
                    chk($sformatf("nop_t%0d_k", t_tb), 32'(dp_k_num), 32'd0);
                    chk($sformatf("nop_t%0d_w", t_tb), dp_in_w, 32'd0);
                end else begin
                    chk($sformatf("rnd_t%0d_en", t_tb), 32'(dp_en_mem_out), 32'd0);
                    chk($sformatf("rnd_t%0d_addr", t_tb), 32'({dp_mem_in_addr, dp_mem_out_addr}), 32'd0);
                    chk($sformatf("rnd_t%0d_k", t_tb), 32'(dp_k_num), 32'(t_tb));
                    chk($sformatf("rnd_t%0d_w", t_tb), dp_in_w, msg_w[t_tb]);
                end
            end
            if (t_tb == ROUNDS) chk("w_ready_after_last", 32'(w_ready), 32'd0);
            if (out_valid) begin
                chk($sformatf("out_idx%0d", nwords), 32'(out_idx), 32'(nwords));
                got[out_idx] = out_word;
                nwords++;
            end else chk("out_word_idle", out_word, 32'd0);
            if (done) begin
                seen_done = 1'b1;
                latency = cyc + 1;
                chk("busy_at_done", 32'(busy), 32'd0);
            end else chk($sformatf("busy_c%0d", cyc), 32'(busy), 32'd1);
            hs = w_valid && w_ready;
            if (!seen_done) begin
                @(posedge clk);
                if (hs) t_tb++;
                cyc++;
            end
        end
        if (!seen_done) chk("done_timeout", 32'(cyc), 32'd0);
        if (pulse) begin
            @(negedge clk); start = 1'b0;
            repeat (3) begin
                #1;
                chk("post_done_busy", 32'(busy), 32'd0);
                chk("post_done_done", 32'(done), 32'd0);
                @(negedge clk);
            end
        end
    endtask

    task automatic check_words(input string tag, input st8_t got, input st8_t exp_s, input int nw);
        chk({tag, "_nwords"}, 32'(nw), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_word%0d", tag, i), got[i], exp_s[i]);
    endtask

    initial begin
        vec_t vecs [5];
        int   lat, nw, stalls, d0, o0;
        st8_t got, exp_s;

        vecs[0] = '{stall_t: -1, stall_len: 0, exp_lat: 83, exp_a: 32'h506e3058, exp_h: 32'h961f4894, pulse: 1'b0};
        vecs[1] = '{stall_t: 10, stall_len: 5, exp_lat: 88, exp_a: 32'h506e3058, exp_h: 32'h961f4894, pulse: 1'b0};
        vecs[2] = '{stall_t: 0,  stall_len: 3, exp_lat: 86, exp_a: 32'h506e3058, exp_h: 32'h961f4894, pulse: 1'b0};
        vecs[3] = '{stall_t: 63, stall_len: 2, exp_lat: 85, exp_a: 32'h506e3058, exp_h: 32'h961f4894, pulse: 1'b0};
        vecs[4] = '{stall_t: -1, stall_len: 0, exp_lat: 83, exp_a: 32'h506e3058, exp_h: 32'h961f4894, pulse: 1'b1};

        rst_n = 1'b0; start = 1'b0; w_valid = 1'b0; w_data = 32'h0;
        iv_src = SHA_IV; mb_reg = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1 check_idle("reset");
        chk("reset_iv_idx", 32'(iv_idx), 32'd0);
        chk("reset_out_idx", 32'(out_idx), 32'd0);

        load_abc();
        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            run_comp(vecs[i].stall_t, vecs[i].stall_len, 0, vecs[i].pulse, -1, lat, got, nw, stalls);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_a", i), got[0], vecs[i].exp_a);
            chk($sformatf("v%0d_h", i), got[7], vecs[i].exp_h);
            chk($sformatf("v%0d_done_count", i), 32'(done_cnt - d0), 32'd1);
            check_words($sformatf("v%0d", i), got, ref_compress(exp_iv()), nw);
        end

        // Reset while t=30 is pending, then a clean run must still give the "abc" result.
        d0 = done_cnt; o0 = outv_cnt;
        run_comp(-1, 0, 0, 1'b0, 30, lat, got, nw, stalls);
        chk("abort_done_count", 32'(done_cnt - d0), 32'd0);
        chk("abort_out_valid_count", 32'(outv_cnt - o0), 32'd0);
        d0 = done_cnt;
        run_comp(-1, 0, 0, 1'b0, -1, lat, got, nw, stalls);
        chk("rerun_latency", 32'(lat), 32'd83);
        chk("rerun_a", got[0], 32'h506e3058);
        chk("rerun_h", got[7], 32'h961f4894);
        chk("rerun_done_count", 32'(done_cnt - d0), 32'd1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) iv_src[i] = $urandom;
            for (int i = 0; i < 16; i++) msg_w[i] = $urandom;
            expand_schedule();
            exp_s = ref_compress(exp_iv());
            d0 = done_cnt;
            run_comp(-1, 0, 25, r[0], -1, lat, got, nw, stalls);
            chk($sformatf("rand%0d_latency", r), 32'(lat), 32'(83 + stalls));
            chk($sformatf("rand%0d_done_count", r), 32'(done_cnt - d0), 32'd1);
            check_words($sformatf("rand%0d", r), got, exp_s, nw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
